ddr_event_chunk_writer: RTL
===========================

Name: ddr_event_chunk_writer

Overview:
- Single-ID AXI4 write master. Moves event data from one AXI4-Stream source (header or one TURFIO path) into DDR in fixed-length INCR bursts.
- Sits directly upstream of the DDR interconnect. One instance drives each slave port: header plus four TURFIO paths.
- Takes a command (base address and burst count), issues the bursts with bounded outstanding responses, then reports completion and error status.
- Write channels only. The AR/R channels of the slave port are tied off outside this block.

Parameters:
- DATA_WIDTH, 64: AXI W / stream data width in bits (power of two, ≥32).
- ADDR_WIDTH, 40: AXI address width.
- BURST_LEN, 64: beats per burst (1..256); drives awlen = BURST_LEN-1.
- MAX_OUTSTANDING, 4: maximum issued bursts without a B response (1..15).
- AXI_ID, 0: constant value driven on m_axi_awid.

Ports:
- aclk, in, 1: clock; all logic is on the rising edge.
- aresetn, in, 1: already decided. One clock (aclk); reset is synchronous and active-high; this port carries that reset, asserted high despite the name.
- cmd_addr, in, ADDR_WIDTH: base byte address of the chunk.
- cmd_nburst, in, 16: number of bursts to write.
- cmd_valid, in, 1: command valid.
- cmd_ready, out, 1: command accepted when high together with cmd_valid.
- s_axis_tdata, in, DATA_WIDTH: event data.
- s_axis_tvalid, in, 1 / s_axis_tready, out, 1: stream handshake.
- m_axi_awid, out, 3: constant AXI_ID.
- m_axi_awaddr, out, ADDR_WIDTH / m_axi_awlen, out, 8 / m_axi_awsize, out, 3 / m_axi_awburst, out, 2 / m_axi_awcache, out, 4 / m_axi_awprot, out, 3.
- m_axi_awvalid, out, 1 / m_axi_awready, in, 1.
- m_axi_wdata, out, DATA_WIDTH / m_axi_wstrb, out, DATA_WIDTH/8 / m_axi_wlast, out, 1.
- m_axi_wvalid, out, 1 / m_axi_wready, in, 1.
- m_axi_bid, in, 3 / m_axi_bresp, in, 2 / m_axi_bvalid, in, 1 / m_axi_bready, out, 1.
- done, out, 1: one-cycle pulse when a command completes.
- done_err, out, 1: valid with done; high if any bresp != OKAY.

Behaviour:
- Reset values: all valid and ready outputs 0; done 0; done_err 0; burst, beat and outstanding counters 0; state IDLE.
- Constant outputs: awlen = BURST_LEN-1; awsize = log2(DATA_WIDTH/8); awburst = 01 (INCR); awcache = 0011; awprot = 000; wstrb all ones; bready = 1 whenever out of reset.
- Burst alignment: burst bytes BB = BURST_LEN*DATA_WIDTH/8. The low log2(BB) bits of cmd_addr are forced to zero. The address advances by BB per AW and wraps modulo 2^ADDR_WIDTH.
- FSM:
  - IDLE: cmd_ready=1. On cmd_valid, latch the aligned address and nburst, clear the error flag. If nburst=0, go to FIN; otherwise go to RUN.
  - RUN: AW and W run concurrently, subject to the rules below. When all AWs are issued, all W beats are sent and outstanding=0, go to FIN.
  - FIN: done=1 for exactly one cycle, done_err = error flag; next state IDLE. cmd_ready=0 in FIN.
- AW rules:
  - awvalid asserts only while AWs issued < nburst AND outstanding < MAX_OUTSTANDING AND (AWs issued − W bursts completed) < 2.
  - Once asserted, awvalid and awaddr hold stable until awready.
- W rules:
  - wvalid = s_axis_tvalid AND (W bursts completed < AWs issued); s_axis_tready = m_axi_wready under the same qualifier.
  - wdata = s_axis_tdata, combinational pass-through.
  - wlast is high on beat BURST_LEN-1. The beat counter wraps to 0 on the wlast handshake, which also increments the W bursts completed count.
- Outstanding counter: +1 on the AW handshake, −1 on the B handshake, net 0 when both occur in the same cycle.
- Error: the flag is sticky per command and is set on bresp = 10 or 11. bid is ignored.
- aresetn asserted mid-burst: all state returns to reset values next cycle. No completion of the AXI transaction is attempted; the interconnect is reset together with this block.
- A B response arriving in IDLE (protocol violation) is ignored and does not underflow the outstanding counter.

Optional Feature:
- Macro: DDR_EVENT_CHUNK_WRITER_STATS_EN.
- Defined:
  - Adds outputs stat_bursts (32 bits): total B responses since reset, saturating.
  - Adds stat_wstall (32 bits): cycles in RUN with wvalid=1 and wready=0, saturating.
  - Both reset to 0.
- Undefined: ports and counters are absent, and no other behaviour changes.

Test Plan:
- Basic write: cmd_addr=0x1000, nburst=3, BURST_LEN=64, awready/wready/tvalid always 1.
  - 3 AWs at 0x1000, 0x1200, 0x1400; 192 W beats with wlast on beats 63, 127, 191.
  - done pulses once with done_err=0.
- Zero-length command: nburst=0 → no AW or W activity; done pulses 2 cycles after the cmd handshake.
- Unaligned address plus wrap: cmd_addr=0xFF_FFFF_FE17, nburst=2 → awaddr 0xFF_FFFF_FE00 then 0x00_0000_0000.
- Backpressure: bvalid withheld, nburst=8, MAX_OUTSTANDING=4.
  - Exactly 4 AWs issued, then awvalid stays 0.
  - Each bvalid releases one more AW; done occurs only after the 8th B.
- Error response: 2nd of 4 B responses has bresp=10 → done_err=1. The next command with all-OKAY responses gives done_err=0.
- Mid-operation reset: aresetn high for 1 cycle on beat 30 of burst 1.
  - Next cycle: all valids 0, cmd_ready=1.
  - A new command, nburst=1, then completes normally.

Source files
------------

// File: rtl/ddr_event_chunk_writer.sv
// ddr_event_chunk_writer
// Single-ID AXI4 write master: takes a chunk command (base address and burst
// count), moves event data from one AXI4-Stream source into DDR as fixed-length
// INCR bursts with bounded outstanding responses, then reports completion.
//
// Ports:
//   aclk, aresetn          clock; synchronous reset, active HIGH despite the name
//   cmd_*                  chunk command (addr, nburst) with valid/ready
//   s_axis_*               event data stream in
//   m_axi_aw*, m_axi_w*    AXI4 write address / data channels
//   m_axi_b*               AXI4 write response channel (bid ignored)
//   done, done_err         one-cycle completion pulse and sticky error status
//
// Optional: define DDR_EVENT_CHUNK_WRITER_STATS_EN to add the saturating
// stat_bursts (B responses) and stat_wstall (W stall cycles) counters.
module ddr_event_chunk_writer #(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned ADDR_WIDTH      = 40,
  parameter int unsigned BURST_LEN       = 64,
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned AXI_ID          = 0
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [15:0]             cmd_nburst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic [2:0]              m_axi_awid,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [7:0]              m_axi_awlen,
  output logic [2:0]              m_axi_awsize,
  output logic [1:0]              m_axi_awburst,
  output logic [3:0]              m_axi_awcache,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [2:0]              m_axi_bid,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic                    done,
  output logic                    done_err
`ifdef DDR_EVENT_CHUNK_WRITER_STATS_EN
  ,
  output logic [31:0]             stat_bursts,
  output logic [31:0]             stat_wstall
`endif
);

  localparam int unsigned STRB_W      = DATA_WIDTH / 8;
  localparam int unsigned BURST_BYTES = BURST_LEN * STRB_W;
  localparam int unsigned ALIGN_BITS  = $clog2(BURST_BYTES);
  localparam int unsigned SIZE_LOG2   = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIN} state_t;

  state_t      state;
  logic [15:0] nburst_q;
  logic [15:0] aw_cnt;     // AWs issued for the current command
  logic [15:0] wb_cnt;     // W bursts completed for the current command
  logic [7:0]  beat;
  logic [3:0]  outst;
  logic        err_q;

  logic w_open, aw_hs, w_hs, b_hs, aw_can;
  logic unused_bits;

  // Constant AW attributes
  assign m_axi_awid    = 3'(AXI_ID);
  assign m_axi_awlen   = 8'(BURST_LEN - 1);
  assign m_axi_awsize  = 3'(SIZE_LOG2);
  assign m_axi_awburst = 2'b01;
  assign m_axi_awcache = 4'b0011;
  assign m_axi_awprot  = 3'b000;
  assign m_axi_wstrb   = '1;
  assign unused_bits   = ^{m_axi_bid, m_axi_bresp[0]};

  // Handshake readiness follows state directly so it is correct the cycle after reset
  assign cmd_ready    = (state == S_IDLE) && !aresetn;
  assign m_axi_bready = !aresetn;

  // W may only carry beats for bursts whose AW has already been issued
  assign w_open        = (state == S_RUN) && (wb_cnt < aw_cnt);
  assign m_axi_wvalid  = s_axis_tvalid && w_open;
  assign s_axis_tready = m_axi_wready && w_open;
  assign m_axi_wdata   = s_axis_tdata;
  assign m_axi_wlast   = (beat == 8'(BURST_LEN - 1));

  assign aw_hs = m_axi_awvalid && m_axi_awready;
  assign w_hs  = m_axi_wvalid && m_axi_wready;
  // B responses outside RUN or with nothing outstanding are protocol violations; drop them
  assign b_hs  = m_axi_bvalid && m_axi_bready && (state == S_RUN) && (outst != 4'd0);

  // AW may run at most two bursts ahead of W and is bounded by outstanding B responses
  assign aw_can = (aw_cnt < nburst_q) &&
                  (outst < 4'(MAX_OUTSTANDING)) &&
                  (16'(aw_cnt - wb_cnt) < 16'd2);

  // Command FSM with AW/W/B bookkeeping
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      state         <= S_IDLE;
      nburst_q      <= '0;
      aw_cnt        <= '0;
      wb_cnt        <= '0;
      beat          <= '0;
      outst         <= '0;
      err_q         <= 1'b0;
      m_axi_awvalid <= 1'b0;
      m_axi_awaddr  <= '0;
      done          <= 1'b0;
      done_err      <= 1'b0;
    end else begin
      done     <= 1'b0;
      done_err <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            m_axi_awaddr <= {cmd_addr[ADDR_WIDTH-1:ALIGN_BITS], {ALIGN_BITS{1'b0}}};
            nburst_q     <= cmd_nburst;
            err_q        <= 1'b0;
            aw_cnt       <= '0;
            wb_cnt       <= '0;
            beat         <= '0;
            outst        <= '0;
            state        <= (cmd_nburst == 16'd0) ? S_FIN : S_RUN;
          end
        end
        S_RUN: begin
          if (aw_hs) begin
            m_axi_awvalid <= 1'b0;
            m_axi_awaddr  <= m_axi_awaddr + ADDR_WIDTH'(BURST_BYTES);
            aw_cnt        <= aw_cnt + 16'd1;
          end else if (!m_axi_awvalid && aw_can) begin
            m_axi_awvalid <= 1'b1;
          end

          if (w_hs) begin
            if (m_axi_wlast) begin
              beat   <= '0;
              wb_cnt <= wb_cnt + 16'd1;
            end else begin
              beat <= beat + 8'd1;
            end
          end

          if (aw_hs && !b_hs)      outst <= outst + 4'd1;
          else if (!aw_hs && b_hs) outst <= outst - 4'd1;

          if (b_hs && m_axi_bresp[1]) err_q <= 1'b1;

          if ((aw_cnt == nburst_q) && (wb_cnt == nburst_q) &&
              (outst == 4'd0) && !m_axi_awvalid) begin
            state <= S_FIN;
          end
        end
        S_FIN: begin
          done     <= 1'b1;
          done_err <= err_q;
          state    <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DDR_EVENT_CHUNK_WRITER_STATS_EN
  // Saturating activity counters
  always_ff @(posedge aclk) begin
    if (aresetn) begin
      stat_bursts <= '0;
      stat_wstall <= '0;
    end else begin
      if (m_axi_bvalid && m_axi_bready && (stat_bursts != 32'hFFFF_FFFF))
        stat_bursts <= stat_bursts + 32'd1;
      if ((state == S_RUN) && m_axi_wvalid && !m_axi_wready &&
          (stat_wstall != 32'hFFFF_FFFF))
        stat_wstall <= stat_wstall + 32'd1;
    end
  end
`endif

endmodule
